// File: rtl/uart_frame_assembler.sv
// Assembles 6-byte command frames (sync, control, D3..D0) from the UART receiver
// and hands control/inputData to the sandbox process via dataReceived/clearDR.
module uart_frame_assembler #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic        masterClock,
    input  logic        reset,
    input  logic [7:0]  rxByte,
    input  logic        rxValid,
    input  logic        clearDR,
    output logic        dataReceived,
    output logic [7:0]  control,
    output logic [31:0] inputData,
    output logic        overrun,
    output logic        frameTimeout
);

    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);

    typedef enum logic [2:0] {
        HUNT, CTRL, D3, D2, D1, D0, HOLD, RELEASE
    } state_t;

    state_t             state, state_next;
    logic [TIMER_W-1:0] timer, timer_next;
    logic [7:0]         shadow_ctrl, shadow_ctrl_next;
    logic [23:0]        shadow_data, shadow_data_next;
    logic [7:0]         control_next;
    logic [31:0]        data_next;
    logic               ready_next, overrun_next, timeout_next;
    logic               in_frame;

    always_ff @(posedge masterClock or negedge reset) begin
        if (!reset) begin
            state        <= HUNT;
            timer        <= '0;
            shadow_ctrl  <= '0;
            shadow_data  <= '0;
            control      <= '0;
            inputData    <= '0;
            dataReceived <= 1'b0;
            overrun      <= 1'b0;
            frameTimeout <= 1'b0;
        end else begin
            state        <= state_next;
            timer        <= timer_next;
            shadow_ctrl  <= shadow_ctrl_next;
            shadow_data  <= shadow_data_next;
            control      <= control_next;
            inputData    <= data_next;
            dataReceived <= ready_next;
            overrun      <= overrun_next;
            frameTimeout <= timeout_next;
        end
    end

    always_comb begin
        state_next       = state;
        timer_next       = '0;
        shadow_ctrl_next = shadow_ctrl;
        shadow_data_next = shadow_data;
        control_next     = control;
        data_next        = inputData;
        ready_next       = dataReceived;
        overrun_next     = overrun;
        timeout_next     = 1'b0;
        in_frame         = 1'b0;

        case (state)
            HUNT: begin
                if (rxValid && (rxByte == SYNC_BYTE)) begin
                    state_next = CTRL;
                end
            end
            CTRL: begin
                in_frame = 1'b1;
                if (rxValid) begin
                    shadow_ctrl_next = rxByte;
                    state_next       = D3;
                end
            end
            D3: begin
                in_frame = 1'b1;
                if (rxValid) begin
                    shadow_data_next = {shadow_data[15:0], rxByte};
                    state_next       = D2;
                end
            end
            D2: begin
                in_frame = 1'b1;
                if (rxValid) begin
                    shadow_data_next = {shadow_data[15:0], rxByte};
                    state_next       = D1;
                end
            end
            D1: begin
                in_frame = 1'b1;
                if (rxValid) begin
                    shadow_data_next = {shadow_data[15:0], rxByte};
                    state_next       = D0;
                end
            end
            D0: begin
                in_frame = 1'b1;
                if (rxValid) begin
                    control_next = shadow_ctrl;
                    data_next    = {shadow_data, rxByte};
                    ready_next   = 1'b1;
                    state_next   = HOLD;
                end
            end
            HOLD: begin
                if (rxValid) begin
                    overrun_next = 1'b1;
                end
                if (clearDR) begin
                    ready_next = 1'b0;
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (rxValid) begin
                    overrun_next = 1'b1;
                end
                if (!clearDR) begin
                    state_next = HUNT;
                end
            end
            default: state_next = HUNT;
        endcase

        // An accepted byte leaves timer_next at its zero default, so a byte on the expiry cycle wins.
        if (in_frame && !rxValid) begin
            if (timer == TIMER_LAST) begin
                state_next       = HUNT;
                shadow_ctrl_next = '0;
                shadow_data_next = '0;
                timeout_next     = 1'b1;
            end else begin
                timer_next = timer + TIMER_ONE;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Scoreboard bench for uart_frame_assembler: expected frames are queued as bytes are sent
// and popped whenever dataReceived rises.
module tb_uart_frame_assembler;

    localparam logic [7:0] SYNC = 8'hA5;

    typedef struct packed {
        logic [7:0]  ctrl;
        logic [31:0] data;
    } frame_t;

    logic        masterClock = 1'b0;
    logic        reset       = 1'b0;
    logic [7:0]  rxByte      = 8'h00;
    logic        rxValid     = 1'b0;
    logic        clearDR     = 1'b0;
    logic        dataReceived;
    logic [7:0]  control;
    logic [31:0] inputData;
    logic        overrun;
    logic        frameTimeout;

    frame_t sbQueue[$];
    int     checkCount        = 0;
    int     errorCount        = 0;
    int     timeoutPulses     = 0;
    int     timeoutHighCycles = 0;
    logic   testDone          = 1'b0;
    int     pulsesBefore;

    uart_frame_assembler #(
        .SYNC_BYTE(SYNC),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .masterClock(masterClock),
        .reset(reset),
        .rxByte(rxByte),
        .rxValid(rxValid),
        .clearDR(clearDR),
        .dataReceived(dataReceived),
        .control(control),
        .inputData(inputData),
        .overrun(overrun),
        .frameTimeout(frameTimeout)
    );

    always #5 masterClock = ~masterClock;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int gap);
        @(negedge masterClock);
        rxValid = 1'b1;
        rxByte  = b;
        repeat (gap) begin
            @(negedge masterClock);
            rxValid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge masterClock);
            rxValid = 1'b0;
        end
    endtask

    task automatic expectFrame(input logic [7:0] c, input logic [31:0] d);
        frame_t f;
        f.ctrl = c;
        f.data = d;
        sbQueue.push_back(f);
    endtask

    task automatic sendFrame(input logic [7:0] c, input logic [31:0] d, input int gap);
        expectFrame(c, d);
        applyStimulus(SYNC, gap);
        applyStimulus(c, gap);
        for (int i = 3; i >= 0; i--) begin
            applyStimulus(d[i*8 +: 8], gap);
        end
        idle(2);
    endtask

    task automatic doHandshake();
        @(negedge masterClock);
        clearDR = 1'b1;
        @(negedge masterClock);
        checkOutput("dr_fall", {31'b0, dataReceived}, 32'd0);
        clearDR = 1'b0;
        idle(2);
    endtask

    task automatic applyReset(input int cycles);
        @(negedge masterClock);
        reset   = 1'b0;
        rxValid = 1'b0;
        clearDR = 1'b0;
        repeat (cycles) @(negedge masterClock);
        checkOutput("rst_dr", {31'b0, dataReceived}, 32'd0);
        checkOutput("rst_ctrl", {24'b0, control}, 32'd0);
        checkOutput("rst_data", inputData, 32'd0);
        checkOutput("rst_ovr", {31'b0, overrun}, 32'd0);
        checkOutput("rst_to", {31'b0, frameTimeout}, 32'd0);
        reset = 1'b1;
        idle(1);
    endtask

    // Scoreboard pop on each new frame, plus timeout pulse bookkeeping.
    initial begin
        logic prevDr = 1'b0;
        logic prevTo = 1'b0;
        frame_t f;
        forever begin
            @(negedge masterClock);
            if (dataReceived && !prevDr) begin
                checkOutput("frame_expected", {31'b0, sbQueue.size() > 0}, 32'd1);
                if (sbQueue.size() > 0) begin
                    f = sbQueue.pop_front();
                    checkOutput("frame_ctrl", {24'b0, control}, {24'b0, f.ctrl});
                    checkOutput("frame_data", inputData, f.data);
                end
            end
            if (frameTimeout) timeoutHighCycles++;
            if (frameTimeout && !prevTo) timeoutPulses++;
            prevDr = dataReceived;
            prevTo = frameTimeout;
        end
    end

    initial begin
        repeat (20000) @(posedge masterClock);
        checkOutput("watchdog_done", {31'b0, testDone}, 32'd1);
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

    initial begin
        applyReset(3);

        // Nominal frame with 10-cycle gaps, then a back-to-back frame
        sendFrame(8'h03, 32'hDEADBEEF, 10);
        checkOutput("nom_dr", {31'b0, dataReceived}, 32'd1);
        checkOutput("nom_ctrl", {24'b0, control}, 32'h03);
        checkOutput("nom_data", inputData, 32'hDEADBEEF);
        doHandshake();
        checkOutput("nom_hold_ctrl", {24'b0, control}, 32'h03);
        checkOutput("nom_hold_data", inputData, 32'hDEADBEEF);
        sendFrame(8'h00, 32'h00000001, 0);
        checkOutput("nom2_data", inputData, 32'h00000001);
        doHandshake();

        // Hunt past junk, sync byte inside the frame is data
        expectFrame(8'hA5, 32'h01020304);
        applyStimulus(8'h11, 0);
        applyStimulus(8'h22, 0);
        applyStimulus(8'hA5, 0);
        applyStimulus(8'hA5, 0);
        applyStimulus(8'h01, 0);
        applyStimulus(8'h02, 0);
        applyStimulus(8'h03, 0);
        applyStimulus(8'h04, 0);
        idle(2);
        checkOutput("hunt_ctrl", {24'b0, control}, 32'hA5);
        checkOutput("hunt_data", inputData, 32'h01020304);
        checkOutput("hunt_ovr", {31'b0, overrun}, 32'd0);
        doHandshake();

        // Partial frame abandoned by timeout, then recovery
        pulsesBefore = timeoutPulses;
        applyStimulus(SYNC, 0);
        applyStimulus(8'h07, 0);
        applyStimulus(8'h12, 0);
        idle(20);
        checkOutput("to_pulses", timeoutPulses, pulsesBefore + 1);
        checkOutput("to_dr", {31'b0, dataReceived}, 32'd0);
        sendFrame(8'h01, 32'h00000002, 0);
        checkOutput("to_recover", inputData, 32'h00000002);
        doHandshake();

        // Every byte lands exactly on the expiry cycle
        pulsesBefore = timeoutPulses;
        sendFrame(8'h09, 32'h11223344, 15);
        checkOutput("edge_pulses", timeoutPulses, pulsesBefore);
        checkOutput("edge_data", inputData, 32'h11223344);
        doHandshake();

        // One cycle later than the boundary the frame is lost
        pulsesBefore = timeoutPulses;
        applyStimulus(SYNC, 0);
        applyStimulus(8'h09, 16);
        applyStimulus(8'h11, 0);
        applyStimulus(8'h22, 0);
        applyStimulus(8'h33, 0);
        applyStimulus(8'h44, 0);
        idle(3);
        checkOutput("late_pulses", timeoutPulses, pulsesBefore + 1);
        checkOutput("late_dr", {31'b0, dataReceived}, 32'd0);

        // Overrun while a frame is pending; SYNC dropped in RELEASE
        sendFrame(8'h42, 32'hCAFEBABE, 0);
        applyStimulus(8'h55, 0);
        idle(2);
        checkOutput("ovr_set", {31'b0, overrun}, 32'd1);
        checkOutput("ovr_dr", {31'b0, dataReceived}, 32'd1);
        checkOutput("ovr_ctrl", {24'b0, control}, 32'h42);
        checkOutput("ovr_data", inputData, 32'hCAFEBABE);
        @(negedge masterClock);
        clearDR = 1'b1;
        idle(2);
        checkOutput("rel_dr", {31'b0, dataReceived}, 32'd0);
        applyStimulus(SYNC, 1);
        clearDR = 1'b0;
        applyStimulus(8'h01, 0);
        applyStimulus(8'h02, 0);
        applyStimulus(8'h03, 0);
        applyStimulus(8'h04, 0);
        applyStimulus(8'h05, 0);
        idle(3);
        checkOutput("rel_nodr", {31'b0, dataReceived}, 32'd0);

        // Earliest re-acceptance: clearDR low on one edge, SYNC on the next
        @(negedge masterClock);
        clearDR = 1'b1;
        idle(2);
        clearDR = 1'b0;
        sendFrame(8'h0F, 32'h0000000F, 0);
        checkOutput("reacc_dr", {31'b0, dataReceived}, 32'd1);
        doHandshake();
        checkOutput("ovr_sticky", {31'b0, overrun}, 32'd1);

        // Reset mid-frame clears everything and discards the partial frame
        applyStimulus(SYNC, 0);
        applyStimulus(8'h01, 0);
        applyStimulus(8'hAA, 0);
        applyReset(3);
        applyStimulus(8'h02, 0);
        applyStimulus(8'h03, 0);
        applyStimulus(8'h04, 0);
        applyStimulus(8'h05, 0);
        idle(3);
        checkOutput("postrst_dr", {31'b0, dataReceived}, 32'd0);
        sendFrame(8'h5A, 32'h01234567, 0);
        checkOutput("postrst_data", inputData, 32'h01234567);

        // clearDR rising together with a byte in HOLD
        @(negedge masterClock);
        clearDR = 1'b1;
        rxValid = 1'b1;
        rxByte  = 8'h77;
        @(negedge masterClock);
        rxValid = 1'b0;
        checkOutput("sim_dr", {31'b0, dataReceived}, 32'd0);
        checkOutput("sim_ovr", {31'b0, overrun}, 32'd1);
        clearDR = 1'b0;
        idle(3);

        checkOutput("sb_empty", sbQueue.size(), 32'd0);
        checkOutput("to_width", timeoutHighCycles, timeoutPulses);
        testDone = 1'b1;
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
